operand_holder_bank: RTL
========================

Name: operand_holder_bank

Overview:
- Parametrised multi-channel operand holder for the calculator datapath.
- Samples the operand input bus every clock and tracks how long it has been stable.
- On a LOAD command, commits the input into the selected channel's register only after the input has been stable for DEPTH consecutive samples.
- Supports clearing one channel or all channels, and reports per-channel valid flags plus a one-cycle load-complete pulse to the control FSM.

Parameters:
- WIDTH, 8: operand width in bits.
- DEPTH, 2: consecutive equal samples required before commit (legal range 2..16).
- CHANNELS, 2: number of operand registers (legal range 1..8).
- CH_W, 3: width of the channel-select port (must satisfy 2**CH_W >= CHANNELS).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- din  in  WIDTH  operand input bus.
- sel  in  3  command code: 010 LOAD, 100 CLEAR_SEL, 101 CLEAR_ALL, all other codes HOLD.
- chan  in  CH_W  target channel for LOAD and CLEAR_SEL.
- out_flat  out  CHANNELS*WIDTH  registered operands; channel i occupies bits [i*WIDTH +: WIDTH].
- valid  out  CHANNELS  bit i is 1 when channel i holds a committed operand.
- load_done  out  1  one-cycle pulse on the edge that commits a LOAD.
- stable  out  1  combinational; din qualifies for commit this cycle.

Behaviour:
- Reset (async assert, sync-free release): out_flat=0, valid=0, load_done=0, FSM=IDLE, prev=0, cnt=0.
- Stability tracker runs every cycle regardless of sel:
  - On each edge: prev<=din.
  - cnt<=0 if din!=prev, else cnt<=min(cnt+1, DEPTH-1).
  - cnt width is clog2(DEPTH).
  - stable = (din==prev) && (cnt >= DEPTH-2).
  - Net effect: commit happens at the DEPTH-th consecutive edge at which din holds the same value.
- chan >= CHANNELS counts as invalid:
  - LOAD with invalid chan: FSM stays IDLE, no write, no pulse.
  - CLEAR_SEL with invalid chan: no-op.
- FSM states and transitions:
  - IDLE:
    - sel==LOAD, chan valid, stable: write din to out[chan], set valid[chan], load_done=1 next cycle, go LOCKED.
    - sel==LOAD, chan valid, not stable: go WAIT and latch chan into chan_q.
  - WAIT:
    - sel!=LOAD: go IDLE with no write (abandoned load).
    - chan!=chan_q: reload chan_q and force cnt<=0, so counting restarts.
    - stable: commit to chan_q as above, go LOCKED.
  - LOCKED:
    - No further writes while sel stays LOAD, even if din changes: exactly one commit per LOAD assertion.
    - sel!=LOAD: go IDLE.
- Clear commands (act in any state and take priority over FSM progress; FSM goes to IDLE):
  - CLEAR_SEL: out[chan]<=0, valid[chan]<=0.
  - CLEAR_ALL: all outputs and valid bits <=0.
- Latency: output update and load_done are visible one cycle after the committing edge. load_done is never asserted on two consecutive cycles.
- Reset asserted mid-WAIT or LOCKED: immediate return to the reset values listed above. The stability history is lost and counting restarts after release.
- An operand equal to 0 is legal; valid distinguishes a committed zero from a cleared register.

Decomposition:
- Package operand_holder_pkg:
  - sel codes: SEL_LOAD=3'b010, SEL_CLR_SEL=3'b100, SEL_CLR_ALL=3'b101.
  - FSM state encoding: IDLE, WAIT, LOCKED.
- Sub-module stability_detector (params WIDTH, DEPTH):
  - Owns prev and cnt, plus a restart input.
  - Outputs stable.
- Top level holds the FSM, chan_q, the register array, valid and load_done.

Test Plan:
- Defaults. Reset, then din=8'h3C held, sel=010, chan=0 from cycle 0 → commit on the 2nd edge with din==3C. out[0]=3C, valid=01, a single load_done pulse; out[1] stays 0.
- DEPTH=4. din toggles 11,12,11, then holds 11 under LOAD → no commit until 4 consecutive 11 samples. Then out[chan]=11 and exactly one load_done.
- LOAD held 20 cycles with din changing 55→AA after commit → out stays 55 (LOCKED). Drop sel to 000, then reassert LOAD with AA stable → out=AA, second pulse.
- CHANNELS=4. Load ch1=07 and ch3=09, then CLEAR_SEL chan=1 → out[1]=0, valid=1000. Then CLEAR_ALL → all 0, valid=0000.
- In WAIT, switch chan 0→2 mid-count → counting restarts. Commit lands in ch2 only; ch0 unchanged. LOAD with chan=5 and CHANNELS=4 → no write, no pulse.
- Assert reset_n low asynchronously (between edges) during WAIT → outputs 0 immediately. After release, a stable din under LOAD needs a full DEPTH samples before commit.

Source files
------------

// File: rtl/operand_holder_bank_pkg.sv
// Shared command codes, FSM encoding and sizing helper for the operand holder bank.
package operand_holder_pkg;

    localparam logic [2:0] SEL_LOAD    = 3'b010;
    localparam logic [2:0] SEL_CLR_SEL = 3'b100;
    localparam logic [2:0] SEL_CLR_ALL = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Stability counter width; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/operand_holder_bank_stability_detector.sv
// Tracks how many consecutive edges din has held its value; flags when the
// next edge would be the DEPTH-th equal sample.
module stability_detector
    import operand_holder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             restart,
    output logic             stable
);

    localparam int unsigned        CNT_W   = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W:0]     THRESH  = (CNT_W + 1)'(DEPTH - 1);

    logic [WIDTH-1:0] prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             same_c;

    assign same_c = (din == prev_q);

    // Saturating run-length counter, cleared on a change or an explicit restart.
    always_comb begin
        cnt_d = '0;
        if (!restart && same_c) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            prev_q <= din;
            cnt_q  <= cnt_d;
        end
    end

    // cnt >= DEPTH-2, written without a compare-against-zero at DEPTH=2.
    assign stable = same_c && (({1'b0, cnt_q} + (CNT_W + 1)'(1)) >= THRESH);

endmodule

// File: rtl/operand_holder_bank.sv
// Multi-channel operand register bank: commits din into a selected channel
// once it has been stable long enough, with per-channel and global clear.
module operand_holder_bank
    import operand_holder_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CH_W     = 3
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           din,
    input  logic [2:0]                 sel,
    input  logic [CH_W-1:0]            chan,
    output logic [CHANNELS*WIDTH-1:0]  out_flat,
    output logic [CHANNELS-1:0]        valid,
    output logic                       load_done,
    output logic                       stable
);

    state_e            state_q;
    logic [CH_W-1:0]   chan_q;
    logic [WIDTH-1:0]  regs_q [CHANNELS];

    logic                is_load_c;
    logic                clr_sel_c;
    logic                clr_all_c;
    logic                chan_ok_c;
    logic                restart_c;
    logic                commit_c;
    logic [CHANNELS-1:0] hit_c;

    assign is_load_c = (sel == SEL_LOAD);
    assign clr_sel_c = (sel == SEL_CLR_SEL);
    assign clr_all_c = (sel == SEL_CLR_ALL);
    assign chan_ok_c = (32'(chan) < CHANNELS);

    // Switching target channel mid-wait throws away the partial stability count.
    assign restart_c = (state_q == WAIT) && is_load_c && (chan != chan_q);

    stability_detector #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stab (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (din),
        .restart (restart_c),
        .stable  (stable)
    );

    always_comb begin
        hit_c = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            hit_c[i] = chan_ok_c && (32'(chan) == i);
        end
    end

    // A commit needs a valid channel; in WAIT it must also still match chan_q.
    always_comb begin
        commit_c = 1'b0;
        if (is_load_c && chan_ok_c) begin
            case (state_q)
                IDLE:    commit_c = stable;
                WAIT:    commit_c = stable && (chan == chan_q);
                default: commit_c = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            chan_q    <= '0;
            load_done <= 1'b0;
            valid     <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            load_done <= commit_c;

            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (clr_all_c || (clr_sel_c && hit_c[i])) begin
                    regs_q[i] <= '0;
                    valid[i]  <= 1'b0;
                end else if (commit_c && hit_c[i]) begin
                    regs_q[i] <= din;
                    valid[i]  <= 1'b1;
                end
            end

            if (clr_all_c || clr_sel_c) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (is_load_c && chan_ok_c) begin
                            if (stable) begin
                                state_q <= LOCKED;
                            end else begin
                                state_q <= WAIT;
                                chan_q  <= chan;
                            end
                        end
                    end
                    WAIT: begin
                        if (!is_load_c) begin
                            state_q <= IDLE;
                        end else if (chan != chan_q) begin
                            // Retargeting to a nonexistent channel abandons the load.
                            if (chan_ok_c) begin
                                chan_q <= chan;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else if (stable) begin
                            state_q <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (!is_load_c) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        out_flat = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            out_flat[i*WIDTH +: WIDTH] = regs_q[i];
        end
    end

endmodule
